conv_ibuf: RTL and testbench
============================

CONV_IBUF -- requirements
Module: conv_ibuf

Interface
REQ-001 The module SHALL have parameter input_size, default 201, meaning the number of input elements per inference.
REQ-002 The module SHALL have parameter xbar_size, default 256, meaning the crossbar rows per CIM tile.
REQ-003 The module SHALL have parameter datatype_size, default 8, meaning the element width in bits.
REQ-004 The module SHALL have parameter v_cim_tiles, default ceil(input_size/xbar_size), meaning the number of vertical CIM tiles.
REQ-005 The module SHALL have port clk, input, 1 bit: the clock.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The module SHALL have port i_start, input, 1 bit: the previous layer signals that a stream begins.
REQ-008 The module SHALL have port i_valid, input, 1 bit: i_data is valid this cycle.
REQ-009 The module SHALL have port i_data, input, datatype_size bits: the input element.
REQ-010 The module SHALL have port i_cim_busy, input, 1 bit: the downstream CIM/conv_func pipeline is busy.
REQ-011 The module SHALL have port o_busy, output, 1 bit: the buffer is not accepting a new i_start.
REQ-012 The module SHALL have port o_cim_we, output, v_cim_tiles bits: one-hot per-tile input-register write enable.
REQ-013 The module SHALL have port o_cim_addr, output, $clog2(xbar_size) bits: the row address within the tile.
REQ-014 The module SHALL have port o_cim_data, output, datatype_size bits: the row write data.
REQ-015 The module SHALL have port o_cim_start, output, 1 bit: a one-cycle pulse that starts the CIM compute.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, PAD, WAIT_CIM and START; element counter cnt SHALL range over 0..v_cim_tiles*xbar_size-1.
REQ-017 In IDLE, o_busy=0; i_start=1 SHALL move the FSM to LOAD and clear cnt; otherwise the FSM SHALL stay in IDLE.
REQ-018 In LOAD, each cycle with i_valid=1 SHALL accept i_data at index cnt and increment cnt; cycles with i_valid=0 SHALL hold cnt and produce no write.
REQ-019 An accepted element SHALL appear one cycle later, registered: o_cim_we[cnt/xbar_size]=1 (other bits 0), o_cim_addr=cnt%xbar_size, o_cim_data=i_data.
REQ-020 Accepting element input_size-1 SHALL move the FSM to PAD if CONV_IBUF_ZERO_PAD_EN is defined and input_size<v_cim_tiles*xbar_size, otherwise to WAIT_CIM.
REQ-021 In PAD, the module SHALL write 0 to every index input_size..v_cim_tiles*xbar_size-1, one per cycle with the same registered timing, then enter WAIT_CIM; i_valid SHALL be ignored in PAD.
REQ-022 In WAIT_CIM, i_cim_busy=0 SHALL move the FSM to START; i_cim_busy=1 SHALL hold WAIT_CIM indefinitely.
REQ-023 In START, o_cim_start=1 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-024 o_busy SHALL be 1 in LOAD, PAD, WAIT_CIM and START.
REQ-025 i_start received in any state other than IDLE SHALL be ignored.
REQ-026 i_valid received in IDLE, WAIT_CIM or START SHALL be ignored, with no write.
REQ-027 The final write SHALL always precede o_cim_start by at least one cycle.

Reset
REQ-028 When rst=1, the FSM SHALL go to IDLE, cnt=0, and o_busy, o_cim_we, o_cim_addr, o_cim_data and o_cim_start SHALL all be 0 on the next edge.
REQ-029 Reset asserted mid-LOAD or mid-PAD SHALL abort the stream with no further writes and no o_cim_start; rst SHALL take priority over i_start.

Configuration
REQ-030 With macro CONV_IBUF_ZERO_PAD_EN defined, the PAD state SHALL be compiled in and unused crossbar rows SHALL be zeroed on every inference.
REQ-031 Without CONV_IBUF_ZERO_PAD_EN, the PAD state SHALL be absent, unused rows SHALL retain their prior contents, and LOAD SHALL go directly to WAIT_CIM.

Verification
REQ-032 Scenario 1: input_size=201, xbar_size=256, i_valid held high after i_start, i_cim_busy=0 -> 201 writes to tile 0 at addresses 0..200; without the macro, o_cim_start is high exactly 2 cycles after the last accept.
REQ-033 Scenario 2: input_size=300 -> elements 0..255 go to o_cim_we=2'b01 at addresses 0..255, and elements 256..299 go to o_cim_we=2'b10 at addresses 0..43.
REQ-034 Scenario 3: input_size=300 with CONV_IBUF_ZERO_PAD_EN -> 212 zero writes to tile 1 at addresses 44..255 follow the last element, then o_cim_start.
REQ-035 Scenario 4: i_valid toggled 1,0,1,0 with i_cim_busy=1 for 50 cycles after load -> no write on the gap cycles, o_busy=1 throughout, and o_cim_start only after i_cim_busy falls.
REQ-036 Scenario 5: rst pulsed after 100 elements, then i_start -> all outputs are 0, no o_cim_start, and the new stream starts at address 0.
REQ-037 Scenario 6: i_start pulsed during LOAD -> cnt is unaffected and exactly one o_cim_start occurs.

Source files
------------

// File: rtl/conv_ibuf.sv
// rtl/conv_ibuf.sv - input buffer that streams one inference's elements into CIM tile input registers
// Optional macro CONV_IBUF_ZERO_PAD_EN zero-fills unused crossbar rows after each stream.
module conv_ibuf #(
  parameter int input_size    = 201,
  parameter int xbar_size     = 256,
  parameter int datatype_size = 8,
  parameter int v_cim_tiles   = (input_size + xbar_size - 1) / xbar_size
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic                         i_valid,
  input  logic [datatype_size-1:0]     i_data,
  input  logic                         i_cim_busy,
  output logic                         o_busy,
  output logic [v_cim_tiles-1:0]       o_cim_we,
  output logic [$clog2(xbar_size)-1:0] o_cim_addr,
  output logic [datatype_size-1:0]     o_cim_data,
  output logic                         o_cim_start
);

  localparam int TOTAL = v_cim_tiles * xbar_size;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int AW    = $clog2(xbar_size);
  localparam logic [CW-1:0] LAST_IN  = CW'(input_size - 1);
  localparam logic [CW-1:0] XB       = CW'(xbar_size);
`ifdef CONV_IBUF_ZERO_PAD_EN
  localparam logic [CW-1:0] LAST_ALL = CW'(TOTAL - 1);
  localparam bit            DO_PAD   = (input_size < TOTAL);
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef CONV_IBUF_ZERO_PAD_EN
    PAD,
`endif
    WAIT_CIM,
    START
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        tile_idx;
  logic [v_cim_tiles-1:0] tile_sel;
  logic [AW-1:0]        row_addr;

  // Element index cnt maps to tile cnt/xbar_size, row cnt%xbar_size.
  always_comb begin
    tile_idx = cnt / XB;
    tile_sel = v_cim_tiles'(1) << tile_idx;
    row_addr = AW'(cnt % XB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      o_busy      <= 1'b0;
      o_cim_we    <= '0;
      o_cim_addr  <= '0;
      o_cim_data  <= '0;
      o_cim_start <= 1'b0;
    end else begin
      o_cim_we    <= '0;
      o_cim_start <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state  <= LOAD;
            cnt    <= '0;
            o_busy <= 1'b1;
          end
        end
        LOAD: begin
          if (i_valid) begin
            o_cim_we   <= tile_sel;
            o_cim_addr <= row_addr;
            o_cim_data <= i_data;
            cnt        <= cnt + 1'b1;
            if (cnt == LAST_IN) begin
`ifdef CONV_IBUF_ZERO_PAD_EN
              state <= DO_PAD ? PAD : WAIT_CIM;
`else
              state <= WAIT_CIM;
`endif
            end
          end
        end
`ifdef CONV_IBUF_ZERO_PAD_EN
        PAD: begin
          o_cim_we   <= tile_sel;
          o_cim_addr <= row_addr;
          o_cim_data <= '0;
          cnt        <= cnt + 1'b1;
          if (cnt == LAST_ALL) state <= WAIT_CIM;
        end
`endif
        // Start is raised on entry so it lines up with the START state cycle.
        WAIT_CIM: begin
          if (!i_cim_busy) begin
            state       <= START;
            o_cim_start <= 1'b1;
          end
        end
        START: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_ibuf.sv
// tb/tb_conv_ibuf.sv - directed bench for conv_ibuf (one- and two-tile instances)
module tb_conv_ibuf;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic       i_valid;
  logic [7:0] i_data;
  logic       i_cim_busy;

  logic       a_busy, a_start, b_busy, b_start;
  logic [0:0] a_we;
  logic [1:0] b_we;
  logic [7:0] a_addr, a_data, b_addr, b_data;

  logic       sel;
  logic [1:0] we_m;
  logic [7:0] addr_m, data_m;
  logic       busy_m, start_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_ibuf #(.input_size(201), .xbar_size(256), .datatype_size(8)) u_a (
    .clk(clk), .rst(rst), .i_start(start_a), .i_valid(i_valid), .i_data(i_data),
    .i_cim_busy(i_cim_busy), .o_busy(a_busy), .o_cim_we(a_we), .o_cim_addr(a_addr),
    .o_cim_data(a_data), .o_cim_start(a_start)
  );

  conv_ibuf #(.input_size(300), .xbar_size(256), .datatype_size(8)) u_b (
    .clk(clk), .rst(rst), .i_start(start_b), .i_valid(i_valid), .i_data(i_data),
    .i_cim_busy(i_cim_busy), .o_busy(b_busy), .o_cim_we(b_we), .o_cim_addr(b_addr),
    .o_cim_data(b_data), .o_cim_start(b_start)
  );

  assign we_m    = sel ? b_we : {1'b0, a_we};
  assign addr_m  = sel ? b_addr : a_addr;
  assign data_m  = sel ? b_data : a_data;
  assign busy_m  = sel ? b_busy : a_busy;
  assign start_m = sel ? b_start : a_start;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic pulse_start();
    set_start(1'b1);
    tick();
    set_start(1'b0);
    chk("start_busy", {31'd0, busy_m}, 32'd1);
    chk("start_we", {30'd0, we_m}, 32'd0);
  endtask

  task automatic load(input int n, input bit gap, input int start_at);
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        i_valid = 1'b0;
        i_data  = 8'hee;
        tick();
        chk("gap_we", {30'd0, we_m}, 32'd0);
        chk("gap_busy", {31'd0, busy_m}, 32'd1);
      end
      i_valid = 1'b1;
      i_data  = 8'((i * 7 + 3) & 255);
      if (i == start_at) set_start(1'b1);
      tick();
      set_start(1'b0);
      chk("we", {30'd0, we_m}, 32'(1 << (i / 256)));
      chk("addr", {24'd0, addr_m}, 32'(i % 256));
      chk("data", {24'd0, data_m}, 32'((i * 7 + 3) & 255));
    end
  endtask

  task automatic finish(input int n, input int tot, input int busy_cycles);
    i_valid    = 1'b1;
    i_data     = 8'hff;
    i_cim_busy = 1'b0;
`ifdef CONV_IBUF_ZERO_PAD_EN
    for (int j = n; j < tot; j++) begin
      tick();
      chk("pad_we", {30'd0, we_m}, 32'(1 << (j / 256)));
      chk("pad_addr", {24'd0, addr_m}, 32'(j % 256));
      chk("pad_data", {24'd0, data_m}, 32'd0);
      chk("pad_start", {31'd0, start_m}, 32'd0);
    end
`endif
    i_cim_busy = (busy_cycles > 0);
    for (int k = 0; k < busy_cycles; k++) begin
      tick();
      chk("wait_start", {31'd0, start_m}, 32'd0);
      chk("wait_busy", {31'd0, busy_m}, 32'd1);
      chk("wait_we", {30'd0, we_m}, 32'd0);
    end
    i_cim_busy = 1'b0;
    tick();
    chk("cim_start", {31'd0, start_m}, 32'd1);
    chk("cim_start_busy", {31'd0, busy_m}, 32'd1);
    chk("cim_start_we", {30'd0, we_m}, 32'd0);
    tick();
    chk("start_drop", {31'd0, start_m}, 32'd0);
    chk("idle_busy", {31'd0, busy_m}, 32'd0);
    i_valid = 1'b0;
    if (n > tot) $error("FAIL finish_args observed=%0d expected<=%0d", n, tot);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; i_valid = 1'b0;
    i_data = 8'h00; i_cim_busy = 1'b0; sel = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_we_a", {31'd0, a_we}, 32'd0);
    chk("rst_we_b", {30'd0, b_we}, 32'd0);
    chk("rst_busy_a", {31'd0, a_busy}, 32'd0);
    chk("rst_busy_b", {31'd0, b_busy}, 32'd0);
    chk("rst_start", {30'd0, a_start, b_start}, 32'd0);
    chk("rst_addr", {16'd0, a_addr, b_addr}, 32'd0);

    // valid while idle must not write
    i_valid = 1'b1;
    tick();
    chk("idle_valid_we", {29'd0, a_we, b_we}, 32'd0);
    i_valid = 1'b0;

    // one tile, continuous stream
    sel = 1'b0;
    pulse_start();
    load(201, 1'b0, -1);
    finish(201, 256, 0);

    // two tiles
    sel = 1'b1;
    pulse_start();
    load(300, 1'b0, -1);
    finish(300, 512, 0);

    // gapped valid, downstream busy for 50 cycles
    sel = 1'b0;
    pulse_start();
    load(201, 1'b1, -1);
    finish(201, 256, 50);

    // reset mid-load with simultaneous start, then a clean stream
    pulse_start();
    load(100, 1'b0, -1);
    rst = 1'b1;
    start_a = 1'b1;
    i_valid = 1'b1;
    tick();
    chk("mid_rst_we", {31'd0, a_we}, 32'd0);
    chk("mid_rst_addr", {24'd0, a_addr}, 32'd0);
    chk("mid_rst_data", {24'd0, a_data}, 32'd0);
    chk("mid_rst_busy", {31'd0, a_busy}, 32'd0);
    chk("mid_rst_start", {31'd0, a_start}, 32'd0);
    rst = 1'b0;
    start_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_we", {31'd0, a_we}, 32'd0);
      chk("post_rst_busy", {31'd0, a_busy}, 32'd0);
      chk("post_rst_start", {31'd0, a_start}, 32'd0);
    end
    i_valid = 1'b0;
    pulse_start();
    load(201, 1'b0, -1);
    finish(201, 256, 0);

    // start pulse during load is ignored
    sel = 1'b1;
    pulse_start();
    load(300, 1'b0, 50);
    finish(300, 512, 3);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("no_extra_start", {31'd0, b_start}, 32'd0);
      chk("no_extra_busy", {31'd0, b_busy}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
